com_color_scheduler: RTL

- Time-multiplexes the single centre-of-mass datapath across red, green and blue, one colour per frame, round-robin over an enable mask.
- Drives the datapath's colorSelect and detects frame boundaries from the pixel coordinates.
- Waits out the divider latency, then captures xCenter/yCenter into per-colour result registers with valid flags.
- Sits between the video pixel stream and the tracking/game logic that consumes per-colour centres.

---
 rtl/com_color_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/com_color_scheduler.sv
// Round-robin colour scheduler for the shared centre-of-mass datapath.
// Picks one colour per frame and captures its result after the divider settles.
module com_color_scheduler #(
    parameter int DIV_LATENCY = 36,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic [2:0]  colorEnable,
    output logic [1:0]  colorSelect,
    input  logic [9:0]  xCenter,
    input  logic [9:0]  yCenter,
    output logic [9:0]  xRed,
    output logic [9:0]  yRed,
    output logic [9:0]  xGreen,
    output logic [9:0]  yGreen,
    output logic [9:0]  xBlue,
    output logic [9:0]  yBlue,
    output logic [2:0]  valid,
    output logic        updated,
    output logic        overrun
);

    typedef enum logic [1:0] {WAIT, COUNT, CAPTURE} state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] count, countNext;
    logic             primed;
    logic             atOrigin, originPrev, fs;
    logic [1:0]       capColor, nextColor, plusOne, plusTwo;
    logic             startCount, doCapture;
    logic [2:0]       validSet;

    assign atOrigin   = (x == 11'd0) && (y == 10'd0);
    assign fs         = atOrigin && !originPrev;
    assign startCount = fs && primed && colorEnable[colorSelect];
    assign doCapture  = (state == CAPTURE) && colorEnable[capColor];
    assign validSet   = doCapture ? (3'b001 << capColor) : 3'b000;

    always_comb begin
        plusOne = 2'd0;
        plusTwo = 2'd1;
        case (colorSelect)
            2'd0: begin plusOne = 2'd1; plusTwo = 2'd2; end
            2'd1: begin plusOne = 2'd2; plusTwo = 2'd0; end
            default: begin plusOne = 2'd0; plusTwo = 2'd1; end
        endcase
        if (colorEnable[plusOne])
            nextColor = plusOne;
        else if (colorEnable[plusTwo])
            nextColor = plusTwo;
        else
            nextColor = colorSelect;
    end

    always_comb begin
        stateNext = state;
        countNext = count;
        case (state)
            WAIT: ;
            COUNT: begin
                if (count == CNT_W'(1))
                    stateNext = CAPTURE;
                else
                    countNext = count - CNT_W'(1);
            end
            CAPTURE: stateNext = WAIT;
            default: stateNext = WAIT;
        endcase
        // A frame start overrides whatever was pending.
        if (fs) begin
            stateNext = startCount ? COUNT : WAIT;
            if (startCount)
                countNext = CNT_W'(DIV_LATENCY);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            colorSelect <= 2'd0;
            capColor    <= 2'd0;
            primed      <= 1'b0;
            originPrev  <= 1'b0;
            xRed        <= '0;
            yRed        <= '0;
            xGreen      <= '0;
            yGreen      <= '0;
            xBlue       <= '0;
            yBlue       <= '0;
            valid       <= '0;
            updated     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            originPrev <= atOrigin;
            updated    <= doCapture;
            valid      <= (valid | validSet) & colorEnable;
            if (fs) begin
                capColor    <= colorSelect;
                colorSelect <= nextColor;
                primed      <= 1'b1;
                if (state == COUNT)
                    overrun <= 1'b1;
            end
            if (doCapture) begin
                case (capColor)
                    2'd0: begin xRed <= xCenter; yRed <= yCenter; end
                    2'd1: begin xGreen <= xCenter; yGreen <= yCenter; end
                    default: begin xBlue <= xCenter; yBlue <= yCenter; end
                endcase
            end
        end
    end

endmodule
